// File: rtl/sync_filter.sv
// ============================================================================
// sync_filter : multi-channel synchroniser, debounce filter, edge/glitch pulses
// Revision    : 1.0  initial release
// ============================================================================
`default_nettype none

module sync_filter #(
  parameter int                      NUM_CHANNELS  = 4,
  parameter int                      SYNC_DEPTH    = 2,
  parameter int                      FILTER_CYCLES = 4,
  parameter logic [NUM_CHANNELS-1:0] RESET_VAL     = {NUM_CHANNELS{1'b0}}
) (
  input  logic                    clk,
  input  logic                    n_rst,
  input  logic [NUM_CHANNELS-1:0] i_async_data,
  input  logic                    i_filter_en,
  output logic [NUM_CHANNELS-1:0] o_sync_data,
  output logic [NUM_CHANNELS-1:0] o_filt_data,
  output logic [NUM_CHANNELS-1:0] o_rise,
  output logic [NUM_CHANNELS-1:0] o_fall,
  output logic [NUM_CHANNELS-1:0] o_glitch
);

  localparam int                   CNT_WIDTH = $clog2(FILTER_CYCLES + 1);
  localparam logic [CNT_WIDTH-1:0] C_THR_MAX = CNT_WIDTH'(FILTER_CYCLES - 1);

  logic [NUM_CHANNELS-1:0] sync_q [SYNC_DEPTH];
  logic [CNT_WIDTH-1:0]    thr;

  always_ff @(posedge clk) begin
    if (!n_rst) begin
      for (int i = 0; i < SYNC_DEPTH; i++) sync_q[i] <= RESET_VAL;
    end else begin
      sync_q[0] <= i_async_data;
      for (int i = 1; i < SYNC_DEPTH; i++) sync_q[i] <= sync_q[i-1];
    end
  end

  assign o_sync_data = sync_q[SYNC_DEPTH-1];

  // Bypass simply collapses the acceptance threshold to zero.
  assign thr = i_filter_en ? C_THR_MAX : '0;

  for (genvar c = 0; c < NUM_CHANNELS; c++) begin : g_ch
    logic                 filt_q, filt_d;
    logic [CNT_WIDTH-1:0] cnt_q, cnt_d;
    logic                 rise_q, rise_d;
    logic                 fall_q, fall_d;
    logic                 glitch_q, glitch_d;
    logic                 sync_bit;

    assign sync_bit = o_sync_data[c];

    always_comb begin
      filt_d   = filt_q;
      cnt_d    = cnt_q;
      rise_d   = 1'b0;
      fall_d   = 1'b0;
      glitch_d = 1'b0;
      if (sync_bit == filt_q) begin
        if (cnt_q != '0) begin
          cnt_d    = '0;
          glitch_d = 1'b1;
        end
      end else if (cnt_q < thr) begin
        cnt_d = cnt_q + 1'b1;
      end else begin
        filt_d = sync_bit;
        cnt_d  = '0;
        rise_d = sync_bit;
        fall_d = ~sync_bit;
      end
    end

    always_ff @(posedge clk) begin
      if (!n_rst) begin
        filt_q   <= RESET_VAL[c];
        cnt_q    <= '0;
        rise_q   <= 1'b0;
        fall_q   <= 1'b0;
        glitch_q <= 1'b0;
      end else begin
        filt_q   <= filt_d;
        cnt_q    <= cnt_d;
        rise_q   <= rise_d;
        fall_q   <= fall_d;
        glitch_q <= glitch_d;
      end
    end

    assign o_filt_data[c] = filt_q;
    assign o_rise[c]      = rise_q;
    assign o_fall[c]      = fall_q;
    assign o_glitch[c]    = glitch_q;
  end

endmodule

`default_nettype wire

// File: tb/tb_sync_filter.sv
// ============================================================================
// tb_sync_filter : directed self-checking bench for sync_filter
// Revision       : 1.0  initial release
// ============================================================================
`default_nettype none

module tb_sync_filter;

  logic       clk;
  logic       n_rst;
  logic [3:0] data;
  logic       en;
  logic [3:0] sync_o, filt_o, rise_o, fall_o, glitch_o;

  int vectors     = 0;
  int miscompares = 0;

  sync_filter #(
    .NUM_CHANNELS (4),
    .SYNC_DEPTH   (2),
    .FILTER_CYCLES(4),
    .RESET_VAL    (4'b0101)
  ) dut (
    .clk         (clk),
    .n_rst       (n_rst),
    .i_async_data(data),
    .i_filter_en (en),
    .o_sync_data (sync_o),
    .o_filt_data (filt_o),
    .o_rise      (rise_o),
    .o_fall      (fall_o),
    .o_glitch    (glitch_o)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Advance one clock, then compare every output 1 time unit after the edge.
  task automatic step(input string tag, input logic [3:0] es, input logic [3:0] ef,
                      input logic [3:0] er, input logic [3:0] efl, input logic [3:0] eg);
    logic [19:0] obs, exp;
    @(posedge clk);
    #1;
    obs = {sync_o, filt_o, rise_o, fall_o, glitch_o};
    exp = {es, ef, er, efl, eg};
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed sync=%b filt=%b rise=%b fall=%b glitch=%b, expected sync=%b filt=%b rise=%b fall=%b glitch=%b",
             tag, sync_o, filt_o, rise_o, fall_o, glitch_o, es, ef, er, efl, eg);
    end
  endtask

  // Stable change: sync follows after 2 edges, filt 4 edges after that.
  task automatic transition(input string tag, input logic [3:0] old_v, input logic [3:0] new_v);
    logic [3:0] r, f;
    r    = new_v & ~old_v;
    f    = old_v & ~new_v;
    data = new_v;
    step(tag, old_v, old_v, 4'b0, 4'b0, 4'b0);
    repeat (4) step(tag, new_v, old_v, 4'b0, 4'b0, 4'b0);
    step(tag, new_v, new_v, r, f, 4'b0);
    step(tag, new_v, new_v, 4'b0, 4'b0, 4'b0);
  endtask

  initial begin
    n_rst = 1'b0;
    en    = 1'b1;
    data  = 4'($urandom);

    // Reset with random inputs, then one cycle after release.
    for (int i = 0; i < 3; i++) begin
      data = 4'($urandom);
      step("reset", 4'b0101, 4'b0101, 4'b0, 4'b0, 4'b0);
    end
    n_rst = 1'b1;
    data  = 4'b0101;
    step("post_reset", 4'b0101, 4'b0101, 4'b0, 4'b0, 4'b0);

    // ch0 falls, then rises back with the full latency.
    transition("ch0_fall", 4'b0101, 4'b0100);
    transition("ch0_rise", 4'b0100, 4'b0101);

    // ch1 high for 3 cycles: rejected, single glitch pulse.
    data = 4'b0111;
    step("short_pulse", 4'b0101, 4'b0101, 4'b0, 4'b0, 4'b0);
    step("short_pulse", 4'b0111, 4'b0101, 4'b0, 4'b0, 4'b0);
    step("short_pulse", 4'b0111, 4'b0101, 4'b0, 4'b0, 4'b0);
    data = 4'b0101;
    step("short_pulse", 4'b0111, 4'b0101, 4'b0, 4'b0, 4'b0);
    step("short_pulse", 4'b0101, 4'b0101, 4'b0, 4'b0, 4'b0);
    step("short_glitch", 4'b0101, 4'b0101, 4'b0, 4'b0, 4'b0010);
    step("short_after", 4'b0101, 4'b0101, 4'b0, 4'b0, 4'b0);

    // ch1 high for 4 cycles: accepted, filt high for 4 cycles.
    data = 4'b0111;
    step("long_pulse", 4'b0101, 4'b0101, 4'b0, 4'b0, 4'b0);
    step("long_pulse", 4'b0111, 4'b0101, 4'b0, 4'b0, 4'b0);
    step("long_pulse", 4'b0111, 4'b0101, 4'b0, 4'b0, 4'b0);
    step("long_pulse", 4'b0111, 4'b0101, 4'b0, 4'b0, 4'b0);
    data = 4'b0101;
    step("long_pulse", 4'b0111, 4'b0101, 4'b0, 4'b0, 4'b0);
    step("long_rise", 4'b0101, 4'b0111, 4'b0010, 4'b0, 4'b0);
    repeat (3) step("long_high", 4'b0101, 4'b0111, 4'b0, 4'b0, 4'b0);
    step("long_fall", 4'b0101, 4'b0101, 4'b0, 4'b0010, 4'b0);
    step("long_after", 4'b0101, 4'b0101, 4'b0, 4'b0, 4'b0);

    // Bypass: ch2 toggles every 2 cycles, filt lags sync by one cycle.
    en   = 1'b0;
    data = 4'b0001;
    step("bypass", 4'b0101, 4'b0101, 4'b0, 4'b0, 4'b0);
    step("bypass", 4'b0001, 4'b0101, 4'b0, 4'b0, 4'b0);
    data = 4'b0101;
    step("bypass_fall", 4'b0001, 4'b0001, 4'b0, 4'b0100, 4'b0);
    step("bypass", 4'b0101, 4'b0001, 4'b0, 4'b0, 4'b0);
    data = 4'b0001;
    step("bypass_rise", 4'b0101, 4'b0101, 4'b0100, 4'b0, 4'b0);
    step("bypass", 4'b0001, 4'b0101, 4'b0, 4'b0, 4'b0);
    data = 4'b0101;
    step("bypass_fall", 4'b0001, 4'b0001, 4'b0, 4'b0100, 4'b0);
    step("bypass", 4'b0101, 4'b0001, 4'b0, 4'b0, 4'b0);
    step("bypass_rise", 4'b0101, 4'b0101, 4'b0100, 4'b0, 4'b0);
    step("bypass_after", 4'b0101, 4'b0101, 4'b0, 4'b0, 4'b0);
    en = 1'b1;

    // Simultaneous opposite edges on ch0 and ch3.
    transition("simul_a", 4'b0101, 4'b1100);
    transition("simul_b", 4'b1100, 4'b0101);

    // Reset while ch1 is two cycles into a pending rise.
    data = 4'b0111;
    step("rst_mid", 4'b0101, 4'b0101, 4'b0, 4'b0, 4'b0);
    step("rst_mid", 4'b0111, 4'b0101, 4'b0, 4'b0, 4'b0);
    step("rst_mid", 4'b0111, 4'b0101, 4'b0, 4'b0, 4'b0);
    step("rst_mid", 4'b0111, 4'b0101, 4'b0, 4'b0, 4'b0);
    n_rst = 1'b0;
    step("rst_mid_held", 4'b0101, 4'b0101, 4'b0, 4'b0, 4'b0);
    step("rst_mid_held", 4'b0101, 4'b0101, 4'b0, 4'b0, 4'b0);
    n_rst = 1'b1;
    transition("rst_release", 4'b0101, 4'b0111);

    // Dropping filter enable mid-count accepts at the next edge.
    data = 4'b0101;
    step("mode_chg", 4'b0111, 4'b0111, 4'b0, 4'b0, 4'b0);
    step("mode_chg", 4'b0101, 4'b0111, 4'b0, 4'b0, 4'b0);
    step("mode_chg", 4'b0101, 4'b0111, 4'b0, 4'b0, 4'b0);
    step("mode_chg", 4'b0101, 4'b0111, 4'b0, 4'b0, 4'b0);
    en = 1'b0;
    step("mode_chg_fall", 4'b0101, 4'b0101, 4'b0, 4'b0010, 4'b0);
    step("mode_chg_after", 4'b0101, 4'b0101, 4'b0, 4'b0, 4'b0);
    en = 1'b1;

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

`default_nettype wire
